// File: rtl/prom_pkg.sv
// Shared types and defaults for the loadable program ROM.
package prom_pkg;

    typedef enum logic [1:0] {
        RUN,
        LOAD,
        DONE
    } prom_state_t;

    localparam int PROM_DATA_W_DEF = 8;
    localparam int PROM_DEPTH_DEF  = 16;

    // Keeps address vectors at least one bit wide for tiny arrays
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prom_onehot_enc.sv
// One-hot to binary encoder for the legacy ring-counter PC address.
// hit_valid is low for a zero or multi-hot input.
module prom_onehot_enc #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [DEPTH-1:0]  onehot,
    output logic [ADDR_W-1:0] bin,
    output logic              hit_valid
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (onehot[i]) bin = bin | ADDR_W'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only when exactly one bit was set
    assign hit_valid = (onehot != '0) && ((onehot & (onehot - 1'b1)) == '0);

endmodule

// File: rtl/prom_loadable.sv
// Program ROM with registered read, tri-state bus drive and a valid/ready image loader.
// Build option PROM_ONEHOT_ADDR_EN: addr is one-hot DEPTH bits instead of binary.
module prom_loadable
    import prom_pkg::*;
#(
    parameter int    DATA_W    = PROM_DATA_W_DEF,
    parameter int    DEPTH     = PROM_DEPTH_DEF,
    parameter int    ADDR_W    = clog2_safe(DEPTH),
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PROM_ONEHOT_ADDR_EN
    input  logic [DEPTH-1:0]  addr,
`else
    input  logic [ADDR_W-1:0] addr,
`endif
    input  logic              epr,
    output logic [DATA_W-1:0] inst,
    input  logic              ld_mode,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] ld_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_hit;
    logic              beat;
    prom_state_t       state;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

`ifdef PROM_ONEHOT_ADDR_EN
    prom_onehot_enc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_enc (
        .onehot    (addr),
        .bin       (rd_addr),
        .hit_valid (rd_hit)
    );
`else
    assign rd_addr = addr;
    assign rd_hit  = 1'b1;
`endif

    // A falling ld_mode aborts the load, so it also vetoes a coincident beat
    assign beat = ld_ready & ld_valid & ld_mode;

    always_ff @(posedge clk) begin
        if (rst_n && beat) mem[ld_cnt] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            ld_cnt   <= '0;
            rd_q     <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            ld_err <= 1'b0;
            case (state)
                RUN: begin
                    rd_q <= rd_hit ? mem[rd_addr] : '0;
                    if (ld_mode) begin
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    rd_q <= '0;
                    if (!ld_mode) begin
                        state    <= RUN;
                        ld_ready <= 1'b0;
                        ld_cnt   <= '0;
                        ld_err   <= 1'b1;
                    end else if (ld_valid) begin
                        if (ld_cnt == ADDR_W'(DEPTH - 1)) begin
                            state    <= DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                            ld_cnt   <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    rd_q <= '0;
                    if (!ld_mode) begin
                        state   <= RUN;
                        ld_done <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    ld_ready <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
        end
    end

    assign inst = epr ? rd_q : 'z;

endmodule

// File: tb/tb_prom_loadable.sv
// Directed + randomized bench for prom_loadable against an array-based image model.
module tb_prom_loadable;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          epr      = 1'b0;
    logic          ld_mode  = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data  = '0;
`ifdef PROM_ONEHOT_ADDR_EN
    logic [DEPTH-1:0] addr = '0;
`else
    logic [AW-1:0]    addr = '0;
`endif
    logic [DW-1:0] inst;
    logic          ld_ready, ld_done, ld_err;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] img [DEPTH];

    always #5 clk = ~clk;

    prom_loadable dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .epr      (epr),
        .inst     (inst),
        .ld_mode  (ld_mode),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_err   (ld_err)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int a);
`ifdef PROM_ONEHOT_ADDR_EN
        addr = DEPTH'(1) << a;
`else
        addr = AW'(a);
`endif
    endtask

    task automatic read_check(input string tag, input int a);
        set_addr(a);
        epr = 1'b1;
        tick;
        check(tag, 32'(inst), 32'(model_mem[a]));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) read_check(tag, a);
    endtask

    // mode 0: valid held high, 1: valid alternating starting low, 2: random valid
    task automatic do_load(input int mode, output int cyc);
        int cnt;
        int ready_cyc;
        logic v;
        cnt = 0;
        ready_cyc = 0;
        cyc = 0;
        epr = 1'b1;
        ld_mode = 1'b1;
        ld_valid = 1'b0;
        tick;
        check("load_enter_ready", 32'(ld_ready), 32'd1);
        while (cnt < DEPTH && cyc < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (ld_ready === 1'b1) ready_cyc++;
            if (cyc == 1) check("load_read_blocked", 32'(inst), 32'd0);
            ld_valid = v;
            ld_data  = img[cnt];
            tick;
            if (v) begin
                model_mem[cnt] = img[cnt];
                cnt++;
            end
            cyc++;
        end
        ld_valid = 1'b0;
        check("load_beats", 32'(cnt), 32'(DEPTH));
        check("load_ready_cycles", 32'(ready_cyc), 32'(cyc));
        check("load_done", 32'(ld_done), 32'd1);
        check("load_ready_low", 32'(ld_ready), 32'd0);
        check("done_read_blocked", 32'(inst), 32'd0);
        // extra beat in DONE must be ignored (verified by later readback)
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        tick;
        check("done_held", 32'(ld_done), 32'd1);
        ld_valid = 1'b0;
        ld_mode  = 1'b0;
        tick;
        check("done_clear", 32'(ld_done), 32'd0);
        check("done_no_err", 32'(ld_err), 32'd0);
    endtask

    task automatic do_abort(input int n, input logic [DW-1:0] d);
        epr = 1'b1;
        ld_mode = 1'b1;
        tick;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = d;
            tick;
            model_mem[i] = d;
        end
        // abort coincides with a valid beat: the beat must be dropped
        ld_mode  = 1'b0;
        ld_valid = 1'b1;
        ld_data  = 8'hC3;
        tick;
        ld_valid = 1'b0;
        check("abort_err_pulse", 32'(ld_err), 32'd1);
        check("abort_ready_low", 32'(ld_ready), 32'd0);
        tick;
        check("abort_err_single", 32'(ld_err), 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic [DW-1:0] d;

        // Reset
        epr = 1'b1;
        tick;
        tick;
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_done", 32'(ld_done), 32'd0);
        check("rst_err", 32'(ld_err), 32'd0);
        check("rst_inst", 32'(inst), 32'd0);
        rst_n = 1'b1;
        tick;

        // Test 1: fixed image, valid held high
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        img[0] = 8'h0F; img[1] = 8'hE0; img[2] = 8'h0F;
        img[3] = 8'h3E; img[4] = 8'hE0; img[5] = 8'hF0;
        do_load(0, cyc);
        check("t1_cycles", 32'(cyc), 32'd16);
        read_check("t1_addr3", 3);
        check("t1_addr3_const", 32'(inst), 32'h3E);

        // Test 2: bus enable
        set_addr(1);
        epr = 1'b0;
        tick;
        checks++;
        assert (inst === 8'bzzzzzzzz || inst === 8'h00) else begin
            failures++;
            $error("FAIL t2_bus_release observed=%h expected=zz", inst);
        end
        epr = 1'b1;
        #1;
        check("t2_bus_drive", 32'(inst), 32'hE0);
        read_all("t1_readback");

        // Test 3: abort after 5 beats over an all-0x11 image
        for (int i = 0; i < DEPTH; i++) img[i] = 8'h11;
        do_load(0, cyc);
        do_abort(5, 8'hAA);
        for (int a = 0; a < DEPTH; a++)
            check("t3_model", 32'(model_mem[a]), (a < 5) ? 32'hAA : 32'h11);
        read_all("t3_readback");

        // Test 4: alternating valid
        for (int i = 0; i < DEPTH; i++) img[i] = DW'(8'h40 + i * 3);
        do_load(1, cyc);
        check("t4_cycles", 32'(cyc), 32'd32);
        read_all("t4_readback");

        // Test 5: reset after 7 beats
        epr = 1'b1;
        ld_mode = 1'b1;
        tick;
        for (int i = 0; i < 7; i++) begin
            d = DW'($urandom);
            ld_valid = 1'b1;
            ld_data  = d;
            tick;
            model_mem[i] = d;
        end
        ld_valid = 1'b0;
        ld_mode  = 1'b0;
        rst_n    = 1'b0;
        tick;
        check("t5_ready", 32'(ld_ready), 32'd0);
        check("t5_err", 32'(ld_err), 32'd0);
        check("t5_inst", 32'(inst), 32'd0);
        rst_n = 1'b1;
        tick;
        check("t5_err_after", 32'(ld_err), 32'd0);
        read_all("t5_partial");
        do_abort(3, 8'h77);
        read_all("t5_restart");

        // Randomized loads, aborts and reads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
            do_load(2, cyc);
            n = $urandom_range(1, DEPTH - 1);
            do_abort(n, DW'($urandom));
            for (int k = 0; k < 12; k++) read_check("rand_read", $urandom_range(0, DEPTH - 1));
        end

`ifdef PROM_ONEHOT_ADDR_EN
        // Test 6: one-hot addressing, zero and multi-hot
        epr = 1'b1;
        addr = 16'h0040;
        tick;
        check("t6_hot6", 32'(inst), 32'(model_mem[6]));
        addr = 16'h0041;
        tick;
        check("t6_multihot", 32'(inst), 32'd0);
        addr = 16'h0000;
        tick;
        check("t6_zero", 32'(inst), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
